// File: rtl/row_packer.sv
// row_packer: gathers a scan-order pixel stream into full-width rows using two
// ping-pong row buffers, so one row can fill while the other waits downstream.
//
// Ports:
//   clk, reset            single rising-edge clock, asynchronous active-high reset
//   pix_data/pix_valid/pix_last/pix_ready   incoming pixel stream (valid/ready)
//   row_data/row_len/row_valid/row_ready    packed output row (valid/ready)
//   row_count             rows handed downstream since reset (wraps at 256)
//   short_row, overrun    sticky row-length error flags
//   clear_err             synchronous clear of the sticky flags
module row_packer #(
  parameter int unsigned PIXELS = 120,
  parameter int unsigned PIXW   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXW-1:0]        pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_last,
  output logic                   pix_ready,
  output logic [PIXELS*PIXW-1:0] row_data,
  output logic [6:0]             row_len,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [7:0]             row_count,
  output logic                   short_row,
  output logic                   overrun,
  input  logic                   clear_err
);

  localparam int unsigned IDXW    = 7;
  localparam int unsigned ROWW    = PIXELS * PIXW;
  localparam int unsigned LASTIDX = PIXELS - 1;

  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROWW-1:0]   r_buf [2];
  logic [IDXW-1:0]   r_len [2];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [IDXW-1:0]   r_idx;
  logic [7:0]        r_count;
  logic              r_short;
  logic              r_over;

  logic w_ready;
  logic w_acc;
  logic w_fill_acc;
  logic w_at_end;
  logic w_done;
  logic w_ovr_set;
  logic w_short_set;
  logic w_row_hs;

  // Acceptance: DROP swallows everything; FILL waits for a free write buffer.
  assign w_ready     = !reset && ((r_state == DROP) || !r_full[r_wr_sel]);
  assign w_acc       = pix_valid && w_ready;
  assign w_fill_acc  = w_acc && (r_state == FILL);
  assign w_at_end    = (r_idx == IDXW'(LASTIDX));
  assign w_done      = w_fill_acc && (pix_last || w_at_end);
  assign w_ovr_set   = w_fill_acc && w_at_end && !pix_last;
  assign w_short_set = w_fill_acc && pix_last && !w_at_end;
  assign w_row_hs    = r_full[r_rd_sel] && row_ready;

  // Fill state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // Fill next-state: a row that hits full width without pix_last drops the tail.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_ovr_set)           w_state_nxt = DROP;
      DROP:    if (w_acc && pix_last)   w_state_nxt = FILL;
      default:                          w_state_nxt = FILL;
    endcase
  end

  // Row buffers, pointers, counters and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_len[0] <= '0;
      r_len[1] <= '0;
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_idx    <= '0;
      r_count  <= '0;
      r_short  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      // Zeroing on handshake is what makes unfilled slots of a short row read 0.
      if (w_row_hs) begin
        r_full[r_rd_sel] <= 1'b0;
        r_buf[r_rd_sel]  <= '0;
        r_len[r_rd_sel]  <= '0;
        r_rd_sel         <= ~r_rd_sel;
        r_count          <= r_count + 8'd1;
      end
      // Write buffer is never the one being handed off (it is not full).
      if (w_fill_acc) begin
        for (int i = 0; i < int'(PIXELS); i++) begin
          if (r_idx == IDXW'(i)) r_buf[r_wr_sel][i*PIXW +: PIXW] <= pix_data;
        end
        if (w_done) begin
          r_full[r_wr_sel] <= 1'b1;
          r_len[r_wr_sel]  <= r_idx + 7'd1;
          r_wr_sel         <= ~r_wr_sel;
          r_idx            <= '0;
        end else begin
          r_idx <= r_idx + 7'd1;
        end
      end
      // A set event in the same cycle as clear_err wins.
      r_short <= (r_short && !clear_err) || w_short_set;
      r_over  <= (r_over  && !clear_err) || w_ovr_set;
    end
  end

  assign pix_ready = w_ready;
  assign row_valid = r_full[r_rd_sel];
  assign row_data  = r_buf[r_rd_sel];
  assign row_len   = r_len[r_rd_sel];
  assign row_count = r_count;
  assign short_row = r_short;
  assign overrun   = r_over;

endmodule

// File: tb/tb_row_packer.sv
// Bench for row_packer: directed pixel streams, a row-level queue model checked
// every cycle, plus literal expectations on captured rows.
module tb_row_packer;

  localparam int unsigned PIXELS = 120;
  localparam int unsigned PIXW   = 8;
  localparam int unsigned ROWW   = PIXELS * PIXW;

  logic            clk = 1'b0;
  logic            reset;
  logic [PIXW-1:0] pix_data;
  logic            pix_valid;
  logic            pix_last;
  logic            pix_ready;
  logic [ROWW-1:0] row_data;
  logic [6:0]      row_len;
  logic            row_valid;
  logic            row_ready;
  logic [7:0]      row_count;
  logic            short_row;
  logic            overrun;
  logic            clear_err;

  row_packer #(.PIXELS(PIXELS), .PIXW(PIXW)) dut (
    .clk(clk), .reset(reset),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .row_data(row_data), .row_len(row_len), .row_valid(row_valid), .row_ready(row_ready),
    .row_count(row_count), .short_row(short_row), .overrun(overrun), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [ROWW-1:0] r, input int i);
    return r[i*8 +: 8];
  endfunction

  // Model: rows that have been completed but not yet taken downstream.
  logic [ROWW-1:0] q_row [$];
  int              q_len [$];
  logic [ROWW-1:0] m_cur;
  int              m_n;
  bit              m_drop;
  logic [7:0]      m_count;
  bit              m_short;
  bit              m_over;
  // Last row actually delivered by the DUT, for literal checks.
  logic [ROWW-1:0] cap_row;
  int              cap_len;

  always @(negedge clk) begin : compare
    bit hs, acc, rdy, ss, so;
    if (reset) begin
      q_row.delete(); q_len.delete();
      m_cur = '0; m_n = 0; m_drop = 0; m_count = 0; m_short = 0; m_over = 0;
      chk("rst_pix_ready", pix_ready, 0);
      chk("rst_row_valid", row_valid, 0);
      chk("rst_row_len", row_len, 0);
      chk("rst_row_count", row_count, 0);
      chk("rst_flags", {short_row, overrun}, 0);
    end else begin
      rdy = m_drop || (q_row.size() < 2);
      chk("pix_ready", pix_ready, rdy);
      chk("row_valid", row_valid, q_row.size() > 0);
      chk("row_count", row_count, m_count);
      chk("short_row", short_row, m_short);
      chk("overrun", overrun, m_over);
      if (q_row.size() > 0) begin
        chk("row_len", row_len, q_len[0]);
        total++;
        if (row_data !== q_row[0]) begin
          bad++;
          for (int i = 0; i < int'(PIXELS); i++) begin
            if (byte_of(row_data, i) !== byte_of(q_row[0], i)) begin
              $display("FAIL row_data byte %0d got=%0h want=%0h at %0t",
                       i, byte_of(row_data, i), byte_of(q_row[0], i), $time);
              break;
            end
          end
        end
      end
      // Predict the effect of the coming rising edge.
      hs  = (q_row.size() > 0) && row_ready;
      acc = pix_valid && rdy;
      ss  = 0;
      so  = 0;
      if (hs) begin
        cap_row = row_data;
        cap_len = int'(row_len);
        void'(q_row.pop_front());
        void'(q_len.pop_front());
        m_count = m_count + 8'd1;
      end
      if (acc) begin
        if (m_drop) begin
          if (pix_last) m_drop = 0;
        end else begin
          m_cur[m_n*8 +: 8] = pix_data;
          m_n++;
          if (pix_last || m_n == int'(PIXELS)) begin
            q_row.push_back(m_cur);
            q_len.push_back(m_n);
            if (!pix_last) begin
              m_drop = 1;
              so = 1;
            end else if (m_n < int'(PIXELS)) begin
              ss = 1;
            end
            m_cur = '0;
            m_n = 0;
          end
        end
      end
      m_short = (m_short && !clear_err) || ss;
      m_over  = (m_over  && !clear_err) || so;
    end
  end

  task automatic send_pixel(input logic [7:0] d, input bit last, input bit clr);
    int n;
    bit a;
    pix_data  = d;
    pix_last  = last;
    pix_valid = 1'b1;
    clear_err = clr;
    n = 0;
    forever begin
      @(negedge clk);
      a = pix_ready;
      @(posedge clk);
      #1;
      if (a) break;
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=stalled want=accepted at %0t", $time);
        break;
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic send_row(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) send_pixel(8'(base + i * step), i == n - 1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_data = '0; pix_valid = 0; pix_last = 0;
    row_ready = 0; clear_err = 0;
    idle(3);
    chk("lit_reset_ready", pix_ready, 0);
    reset = 1'b0;
    row_ready = 1'b1;

    // Full row 0..119.
    send_row(120, 0, 1);
    idle(4);
    chk("t1_len", cap_len, 120);
    chk("t1_b5", byte_of(cap_row, 5), 5);
    chk("t1_b119", byte_of(cap_row, 119), 119);
    chk("t1_count", row_count, 1);
    chk("t1_flags", {short_row, overrun}, 0);

    // Short row of 0xAA.
    send_row(5, 'hAA, 0);
    idle(4);
    chk("t2_len", cap_len, 5);
    chk("t2_b4", byte_of(cap_row, 4), 'hAA);
    chk("t2_b5", byte_of(cap_row, 5), 0);
    chk("t2_b119", byte_of(cap_row, 119), 0);
    chk("t2_short", short_row, 1);

    // Overrun: 130 pixels, then a clean short row.
    send_row(130, 0, 1);
    idle(4);
    chk("t3_len", cap_len, 120);
    chk("t3_b119", byte_of(cap_row, 119), 119);
    chk("t3_over", overrun, 1);
    chk("t3_count", row_count, 3);
    send_row(3, 'h11, 'h11);
    idle(4);
    chk("t3b_len", cap_len, 3);
    chk("t3b_b0", byte_of(cap_row, 0), 'h11);
    chk("t3b_b2", byte_of(cap_row, 2), 'h33);
    chk("t3b_b3", byte_of(cap_row, 3), 0);

    // Backpressure: two rows buffered, third row stalls until row_ready.
    row_ready = 1'b0;
    send_row(120, 1, 1);
    send_row(120, 2, 1);
    fork
      send_row(120, 3, 1);
      begin
        idle(4);
        chk("t4_stall_ready", pix_ready, 0);
        chk("t4_valid", row_valid, 1);
        row_ready = 1'b1;
      end
    join
    idle(5);
    chk("t4_count", row_count, 7);
    chk("t4_len", cap_len, 120);
    chk("t4_b0", byte_of(cap_row, 0), 3);
    chk("t4_b119", byte_of(cap_row, 119), 122);

    // Reset mid-row discards the partial row.
    for (int i = 0; i < 60; i++) send_pixel(8'(i + 'h40), 1'b0, 1'b0);
    pulse_reset();
    @(negedge clk);
    chk("t5_ready_after_rst", pix_ready, 1);
    @(posedge clk); #1;
    send_row(120, 9, 1);
    idle(4);
    chk("t5_count", row_count, 1);
    chk("t5_b0", byte_of(cap_row, 0), 9);
    chk("t5_len", cap_len, 120);

    // 256 rows wrap the counter; clear_err racing a short row loses.
    pulse_reset();
    for (int r = 0; r < 256; r++) send_row(120, r, 1);
    idle(4);
    chk("t6_wrap", row_count, 0);
    for (int i = 0; i < 3; i++) send_pixel(8'(i + 1), i == 2, i == 2);
    idle(3);
    chk("t6_short_wins", short_row, 1);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    @(negedge clk);
    chk("t6_cleared", short_row, 0);
    idle(3);
    chk("end_drained", row_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
